// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: opcode bit positions, funct3 sizes, FSM states.
package mem_access_stage_pkg;

    localparam int unsigned OPCODE_W      = 10;
    localparam int unsigned OP_LOAD_WORD  = 2;
    localparam int unsigned OP_STORE_WORD = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
    typedef enum logic {MEM_IDLE, MEM_ACCESS} mem_state_t;

    // Unsupported encodings (011, 110, 111) fall through to word access.
    function automatic size_t access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication, load lane extraction/extension, misalignment.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misaligned
);

    size_t       size;
    logic        zext;
    logic [31:0] lane;

    always_comb begin
        size       = access_size(funct3);
        zext       = funct3[2];
        lane       = rdata >> {offset, 3'b000};
        sel        = 4'b1111;
        wdata      = rs2;
        ldata      = rdata;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                sel   = 4'b0001 << offset;
                wdata = {4{rs2[7:0]}};
                ldata = {{24{~zext & lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                sel        = 4'b0011 << offset;
                wdata      = {2{rs2[15:0]}};
                ldata      = {{16{~zext & lane[15]}}, lane[15:0]};
                misaligned = offset[0];
            end
            default: begin
                misaligned = |offset;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: accepts execute results, runs a req/ack data-memory access, forwards to writeback.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_i_valid,
    input  logic [OPCODE_W-1:0] ex_i_opcode,
    input  logic [2:0]          ex_i_funct3,
    input  logic [DWIDTH-1:0]   ex_i_alu_value,
    input  logic [DWIDTH-1:0]   ex_i_data_rs2,
    input  logic [AWIDTH-1:0]   ex_i_addr_rd,
    input  logic                ex_i_we_reg,
    output logic                mem_o_ready,
    output logic                m_o_req,
    output logic                m_o_we,
    output logic [DWIDTH-1:0]   m_o_addr,
    output logic [DWIDTH-1:0]   m_o_wdata,
    output logic [3:0]          m_o_sel,
    input  logic                m_i_ack,
    input  logic [DWIDTH-1:0]   m_i_rdata,
    output logic                wb_o_valid,
    output logic [AWIDTH-1:0]   wb_o_addr_rd,
    output logic                wb_o_we_reg,
    output logic [DWIDTH-1:0]   wb_o_data_rd,
    output logic                wb_o_misaligned
);

    mem_state_t        state;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [AWIDTH-1:0] rd_q;
    logic              we_q;

    logic              is_load, is_store;
    logic [2:0]        al_f3;
    logic [1:0]        al_off;
    logic [3:0]        al_sel;
    logic [31:0]       al_wdata, al_ldata;
    logic              al_misaligned;

    assign is_load     = ex_i_opcode[OP_LOAD_WORD];
    assign is_store    = ex_i_opcode[OP_STORE_WORD];
    assign mem_o_ready = (state == MEM_IDLE) & ~rst;

    // One aligner serves both phases: request-side outputs matter only in IDLE,
    // load extraction only in ACCESS, so its inputs are muxed on state.
    always_comb begin
        al_f3  = ex_i_funct3;
        al_off = ex_i_alu_value[1:0];
        if (state == MEM_ACCESS) begin
            al_f3  = f3_q;
            al_off = off_q;
        end
    end

    mem_lane_align u_align (
        .funct3     (al_f3),
        .offset     (al_off),
        .rs2        (ex_i_data_rs2),
        .rdata      (m_i_rdata),
        .sel        (al_sel),
        .wdata      (al_wdata),
        .ldata      (al_ldata),
        .misaligned (al_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= MEM_IDLE;
            m_o_req         <= 1'b0;
            m_o_we          <= 1'b0;
            m_o_addr        <= '0;
            m_o_wdata       <= '0;
            m_o_sel         <= '0;
            wb_o_valid      <= 1'b0;
            wb_o_addr_rd    <= '0;
            wb_o_we_reg     <= 1'b0;
            wb_o_data_rd    <= '0;
            wb_o_misaligned <= 1'b0;
            f3_q            <= '0;
            off_q           <= '0;
            rd_q            <= '0;
            we_q            <= 1'b0;
        end else begin
            wb_o_valid      <= 1'b0;
            wb_o_misaligned <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (ex_i_valid) begin
                        if ((is_load | is_store) & al_misaligned) begin
                            wb_o_valid      <= 1'b1;
                            wb_o_misaligned <= 1'b1;
                            wb_o_we_reg     <= 1'b0;
                            wb_o_addr_rd    <= ex_i_addr_rd;
                        end else if (is_load | is_store) begin
                            state     <= MEM_ACCESS;
                            m_o_req   <= 1'b1;
                            m_o_we    <= ~is_load;
                            m_o_addr  <= {ex_i_alu_value[DWIDTH-1:2], 2'b00};
                            m_o_wdata <= al_wdata;
                            m_o_sel   <= al_sel;
                            f3_q      <= ex_i_funct3;
                            off_q     <= ex_i_alu_value[1:0];
                            rd_q      <= ex_i_addr_rd;
                            we_q      <= ex_i_we_reg & is_load;
                        end else begin
                            wb_o_valid   <= 1'b1;
                            wb_o_addr_rd <= ex_i_addr_rd;
                            wb_o_we_reg  <= ex_i_we_reg;
                            wb_o_data_rd <= ex_i_alu_value;
                        end
                    end
                end
                MEM_ACCESS: begin
                    if (m_i_ack) begin
                        state        <= MEM_IDLE;
                        m_o_req      <= 1'b0;
                        wb_o_valid   <= 1'b1;
                        wb_o_addr_rd <= rd_q;
                        wb_o_we_reg  <= we_q;
                        if (!m_o_we)
                            wb_o_data_rd <= al_ldata;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule
